uartlite_ctrl: RTL

//  Sequences the AXI4-Lite master side of the UART Lite core: one-time FIFO reset, status polling,
//  TX-FIFO writes and RX-FIFO reads. Exposes byte valid/ready streams to the CPU I/O path.

---
 rtl/uartlite_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/uartlite_ctrl.sv
// uartlite_ctrl: AXI4-Lite master sequencer for the UART Lite core.
// Resets the FIFOs once, then polls status and moves bytes between FIFOs and holding buffers.
module uartlite_ctrl #(
    parameter int unsigned POLL_GAP  = 8,
    parameter logic [31:0] CTRL_INIT = 32'd3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        err,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [3:0]  axi_awaddr,
    output logic [2:0]  axi_awprot,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    input  logic        axi_bvalid,
    output logic        axi_bready,
    input  logic [1:0]  axi_bresp,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    output logic [3:0]  axi_araddr,
    output logic [2:0]  axi_arprot,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp
);

    typedef enum logic [3:0] {
        INIT_W, INIT_B, STAT_AR, STAT_R,
        TX_W, TX_B, RX_AR, RX_R, GAP
    } state_t;

    localparam logic [15:0] GAP_LAST =
        (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

    state_t      r_state, w_next;
    logic [15:0] r_gap_cnt;
    logic        r_awvalid, r_wvalid, r_bready;
    logic        r_arvalid, r_rready;
    logic [3:0]  r_awaddr, r_araddr;
    logic [31:0] r_wdata;
    logic        r_err, r_grant;
    logic        r_tx_full;
    logic [7:0]  r_tx_buf;
    logic        r_rx_valid;
    logic [7:0]  r_rx_data;

    logic w_wr_acc, w_ar_acc, w_b_fire, w_r_fire;
    logic w_st_rx, w_st_full;
    logic w_can_tx, w_can_rx, w_both, w_pick_tx;
    logic w_wr_go, w_rd_go;
    logic w_unused;

    assign w_wr_acc = (r_awvalid || r_wvalid)
                   && (!r_awvalid || axi_awready)
                   && (!r_wvalid || axi_wready);
    assign w_ar_acc = r_arvalid && axi_arready;
    assign w_b_fire = r_bready && axi_bvalid;
    assign w_r_fire = r_rready && axi_rvalid;

    // A STAT read with an error response counts as all-zero status
    assign w_st_rx   = (axi_rresp == 2'b00) && axi_rdata[0];
    assign w_st_full = (axi_rresp == 2'b00) && axi_rdata[3];
    assign w_can_tx  = r_tx_full && !w_st_full;
    assign w_can_rx  = !r_rx_valid && w_st_rx;
    assign w_both    = w_can_tx && w_can_rx;
    assign w_pick_tx = w_can_tx && (!w_can_rx || !r_grant);

    assign w_wr_go = (w_next == INIT_W || w_next == TX_W)
                  && !r_awvalid && !r_wvalid;
    assign w_rd_go = (w_next == STAT_AR || w_next == RX_AR)
                  && !r_arvalid;
    assign w_unused = ^axi_rdata[31:8];

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            INIT_W:  if (w_wr_acc) w_next = INIT_B;
            INIT_B:  if (w_b_fire) w_next = STAT_AR;
            STAT_AR: if (w_ar_acc) w_next = STAT_R;
            STAT_R: begin
                if (w_r_fire) begin
                    if (w_pick_tx)          w_next = TX_W;
                    else if (w_can_rx)      w_next = RX_AR;
                    else if (POLL_GAP == 0) w_next = STAT_AR;
                    else                    w_next = GAP;
                end
            end
            TX_W:    if (w_wr_acc) w_next = TX_B;
            TX_B:    if (w_b_fire) w_next = STAT_AR;
            RX_AR:   if (w_ar_acc) w_next = RX_R;
            RX_R:    if (w_r_fire) w_next = STAT_AR;
            GAP:     if (r_gap_cnt == GAP_LAST) w_next = STAT_AR;
            default: w_next = INIT_W;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= INIT_W;
            r_gap_cnt <= 16'd0;
        end else begin
            r_state   <= w_next;
            r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 16'd1 : 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_awaddr   <= 4'h0;
            r_araddr   <= 4'h0;
            r_wdata    <= 32'h0;
            r_err      <= 1'b0;
            r_grant    <= 1'b0;
            r_tx_full  <= 1'b0;
            r_tx_buf   <= 8'h0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h0;
        end else begin
            if (w_wr_go) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_awaddr  <= (w_next == TX_W) ? 4'h4 : 4'hC;
                r_wdata   <= (w_next == TX_W) ? {24'h0, r_tx_buf}
                                              : CTRL_INIT;
            end else begin
                if (axi_awready) r_awvalid <= 1'b0;
                if (axi_wready)  r_wvalid  <= 1'b0;
            end

            if (w_wr_acc)        r_bready <= 1'b1;
            else if (axi_bvalid) r_bready <= 1'b0;

            if (w_rd_go) begin
                r_arvalid <= 1'b1;
                r_araddr  <= (w_next == RX_AR) ? 4'h0 : 4'h8;
            end else if (axi_arready) begin
                r_arvalid <= 1'b0;
            end

            if (w_ar_acc)        r_rready <= 1'b1;
            else if (axi_rvalid) r_rready <= 1'b0;

            if ((w_b_fire && axi_bresp != 2'b00)
             || (w_r_fire && axi_rresp != 2'b00))
                r_err <= 1'b1;

            if (r_state == STAT_R && w_r_fire && w_both)
                r_grant <= !r_grant;

            if (tx_valid && !r_tx_full) begin
                r_tx_full <= 1'b1;
                r_tx_buf  <= tx_data;
            end else if (r_state == TX_B && w_b_fire) begin
                r_tx_full <= 1'b0;
            end

            if (r_state == RX_R && w_r_fire && axi_rresp == 2'b00) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= axi_rdata[7:0];
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign axi_awvalid = r_awvalid;
    assign axi_awaddr  = r_awaddr;
    assign axi_awprot  = 3'b000;
    assign axi_wvalid  = r_wvalid;
    assign axi_wdata   = r_wdata;
    assign axi_wstrb   = 4'hF;
    assign axi_bready  = r_bready;
    assign axi_arvalid = r_arvalid;
    assign axi_araddr  = r_araddr;
    assign axi_arprot  = 3'b000;
    assign axi_rready  = r_rready;
    assign tx_ready    = !r_tx_full;
    assign rx_valid    = r_rx_valid;
    assign rx_data     = r_rx_data;
    assign err         = r_err;

endmodule
